// File: rtl/if_stage_pkg.sv
// Shared core definitions for the fetch stage: NOP encoding, default
// reset PC, fetch FSM state encoding and the IF/ID payload layout.
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
    logic        valid;
  } ifid_t;

  // Payload presented to IF/ID for a fetched word at address pc.
  function automatic ifid_t make_ifid(input logic [31:0] pc, input logic [31:0] instr);
    ifid_t r;
    r.pc        = pc;
    r.instr     = instr;
    r.pc_plus_4 = pc + 32'd4;
    r.valid     = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request/grant/rvalid memory
// port, registered IF/ID-facing outputs, one-entry hold buffer for a
// response arriving while downstream is stalled, and redirect draining.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus_4,
  output logic        o_valid
);

  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;       // address of the word being fetched
  logic [31:0]  hold_q, hold_d;   // hold buffer; contents meaningful only in S_HOLD
  ifid_t        out_q, out_d;

  // Only one request can be outstanding; the address is the fetch PC.
  assign o_imem_req  = (state_q == S_REQ);
  assign o_imem_addr = pc_q;

  assign o_pc          = out_q.pc;
  assign o_instruction = out_q.instr;
  assign o_pc_plus_4   = out_q.pc_plus_4;
  assign o_valid       = out_q.valid;

  // State, PC, hold buffer and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC & PC_MASK;
      hold_q          <= NOP_INSTR;
      out_q.pc        <= 32'h0;
      out_q.instr     <= NOP_INSTR;
      out_q.pc_plus_4 <= 32'h4;
      out_q.valid     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  // Next-state, PC advance and output load; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    out_d   = out_q;
    // Unstalled cycles without a load present a bubble.
    if (!i_stall) out_d.valid = 1'b0;

    if (i_redirect) begin
      pc_d        = i_redirect_pc & PC_MASK;
      out_d.valid = 1'b0;
      // A response still owed by memory after this edge must be thrown away.
      if ((state_q == S_REQ && i_imem_gnt) ||
          ((state_q == S_WAIT || state_q == S_DRAIN) && !i_imem_rvalid))
        state_d = S_DRAIN;
      else
        state_d = S_REQ;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   if (i_imem_gnt) state_d = S_WAIT;
        S_WAIT: begin
          if (i_imem_rvalid) begin
            if (i_stall) begin
              hold_d  = i_imem_rdata;
              state_d = S_HOLD;
            end else begin
              out_d   = make_ifid(pc_q, i_imem_rdata);
              pc_d    = pc_q + 32'd4;
              state_d = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            out_d   = make_ifid(pc_q, hold_q);
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
        S_DRAIN: if (i_imem_rvalid) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a behavioural memory with random grant/latency, and
// an in-order instruction stream model that checks every word consumed by
// IF/ID against the expected program-order PC and memory contents.
module tb_if_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_plus_4;
  logic        o_valid;

  if_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_pc(o_pc), .o_instruction(o_instruction), .o_pc_plus_4(o_pc_plus_4), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [31:0] NOP = 32'h00000013;

  int passed = 0;
  int total  = 0;

  // memory model state
  logic        pend;
  logic [31:0] paddr;
  int          pdly;
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;

  // instruction stream model
  logic [31:0] exp_pc;
  int          consumed;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    pend = 1'b0; pdly = 0; paddr = 32'h0;
    exp_pc = 32'h0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // One clock: memory answers, consumer model checks, then the edge.
  task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc);
    logic        was_pend;
    logic [31:0] h_pc, h_in, h_p4;
    logic        h_v;
    was_pend = pend;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = $urandom;
    if (pend) begin
      if (pdly == 0) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = mem_word(paddr);
        pend = 1'b0;
      end else pdly--;
    end
    i_imem_gnt = 1'b0;
    if (o_imem_req) begin
      total++;
      if (was_pend || o_imem_addr[1:0] != 2'b00)
        $display("FAIL imem_req: outstanding=%0b addr=%h, want no outstanding request and aligned addr", was_pend, o_imem_addr);
      else passed++;
      if ($urandom_range(0, 99) < gnt_pct) begin
        i_imem_gnt = 1'b1;
        pend  = 1'b1;
        paddr = o_imem_addr;
        pdly  = $urandom_range(lat_min, lat_max);
      end
    end
    if (o_valid && !stall && !redir) begin
      total++;
      if ({o_pc, o_instruction, o_pc_plus_4} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4})
        $display("FAIL consume: got pc=%h ins=%h p4=%h want pc=%h ins=%h p4=%h",
                 o_pc, o_instruction, o_pc_plus_4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
      else passed++;
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
    h_pc = o_pc; h_in = o_instruction; h_p4 = o_pc_plus_4; h_v = o_valid;
    i_stall = stall; i_redirect = redir; i_redirect_pc = rpc;
    @(negedge i_clk);
    if (redir) begin
      total++;
      if (o_valid !== 1'b0) $display("FAIL redirect_kill: o_valid=%b want 0", o_valid);
      else passed++;
    end else if (stall) begin
      total++;
      if ({o_pc, o_instruction, o_pc_plus_4, o_valid} !== {h_pc, h_in, h_p4, h_v})
        $display("FAIL stall_hold: got %h/%h/%h/%b want %h/%h/%h/%b",
                 o_pc, o_instruction, o_pc_plus_4, o_valid, h_pc, h_in, h_p4, h_v);
      else passed++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    total++;
    if ({o_pc, o_instruction, o_pc_plus_4, o_valid, o_imem_req} !== {32'h0, NOP, 32'h4, 1'b0, 1'b0})
      $display("FAIL reset_values: got pc=%h ins=%h p4=%h v=%b req=%b want 0/00000013/4/0/0",
               o_pc, o_instruction, o_pc_plus_4, o_valid, o_imem_req);
    else passed++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Zero-wait memory, no stall: one instruction every second cycle.
  task automatic test_zero_wait();
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      total++;
      if (o_imem_req !== logic'(t % 2 == 1) || (t % 2 == 1 && o_imem_addr !== 32'(4 * ((t - 1) / 2))))
        $display("FAIL zw_req t=%0d: req=%b addr=%h want req=%b addr=%h", t, o_imem_req, o_imem_addr,
                 t % 2 == 1, 4 * ((t - 1) / 2));
      else passed++;
      total++;
      if (t >= 3 && t % 2 == 1) begin
        if (o_valid !== 1'b1 || o_pc !== 32'(4 * ((t - 3) / 2)) || o_pc_plus_4 !== 32'(4 * ((t - 3) / 2) + 4))
          $display("FAIL zw_out t=%0d: v=%b pc=%h p4=%h want v=1 pc=%h p4=%h", t, o_valid, o_pc, o_pc_plus_4,
                   4 * ((t - 3) / 2), 4 * ((t - 3) / 2) + 4);
        else passed++;
      end else begin
        if (o_valid !== 1'b0) $display("FAIL zw_bubble t=%0d: v=%b want 0", t, o_valid);
        else passed++;
      end
      cycle(1'b0, 1'b0, 32'h0);
    end
  endtask

  // Stall for three cycles exactly when the pc=8 response arrives.
  task automatic test_stall_hold();
    logic found = 1'b0;
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    do_reset();
    for (int t = 0; t < 30 && !found; t++) begin
      if (pend && paddr == 32'h8 && pdly == 0) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0);
    end
    total++;
    if (!found) $display("FAIL stall_setup: pc=8 response never pending, got none want one");
    else passed++;
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    total++;
    if (o_pc !== 32'h4 || o_valid !== 1'b0)
      $display("FAIL stall_prev: pc=%h v=%b want pc=00000004 v=0", o_pc, o_valid);
    else passed++;
    cycle(1'b0, 1'b0, 32'h0);
    total++;
    if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_instruction !== mem_word(32'h8))
      $display("FAIL stall_release: v=%b pc=%h ins=%h want v=1 pc=00000008 ins=%h", o_valid, o_pc, o_instruction, mem_word(32'h8));
    else passed++;
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
  endtask

  // Redirect while waiting on pc=4 with the response still in flight.
  task automatic test_redirect_drain();
    logic found = 1'b0;
    logic seen_req = 1'b0;
    logic done = 1'b0;
    gnt_pct = 100; lat_min = 2; lat_max = 2;
    do_reset();
    for (int t = 0; t < 30 && !found; t++) begin
      if (pend && paddr == 32'h4 && pdly == 2) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0);
    end
    total++;
    if (!found) $display("FAIL drain_setup: WAIT on pc=4 not reached, got none want one");
    else passed++;
    cycle(1'b0, 1'b1, 32'h00000103);
    for (int t = 0; t < 20 && !done; t++) begin
      if (o_imem_req && !seen_req) begin
        seen_req = 1'b1;
        total++;
        if (o_imem_addr !== 32'h00000100) $display("FAIL drain_addr: addr=%h want 00000100", o_imem_addr);
        else passed++;
      end
      if (o_valid) begin
        done = 1'b1;
        total++;
        if (o_pc !== 32'h00000100 || !seen_req) $display("FAIL drain_first: pc=%h req_seen=%b want pc=00000100 req_seen=1", o_pc, seen_req);
        else passed++;
      end
      cycle(1'b0, 1'b0, 32'h0);
    end
    total++;
    if (!done) $display("FAIL drain_timeout: no valid output, got 0 want 1");
    else passed++;
  endtask

  // Redirect coincident with rvalid in WAIT: no drain needed.
  task automatic test_redirect_rvalid();
    logic found = 1'b0;
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    do_reset();
    for (int t = 0; t < 30 && !found; t++) begin
      if (pend && paddr == 32'h4 && pdly == 0) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0);
    end
    cycle(1'b0, 1'b1, 32'h00000200);
    total++;
    if (!found || o_imem_req !== 1'b1 || o_imem_addr !== 32'h00000200 || o_valid !== 1'b0)
      $display("FAIL redir_rvalid: setup=%b req=%b addr=%h v=%b want 1/1/00000200/0", found, o_imem_req, o_imem_addr, o_valid);
    else passed++;
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
  endtask

  // Redirect while stalled with a valid instruction on the outputs.
  task automatic test_redirect_stalled();
    logic found = 1'b0;
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    do_reset();
    for (int t = 0; t < 30 && !found; t++) begin
      if (o_valid) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0);
    end
    cycle(1'b1, 1'b0, 32'h0);
    total++;
    if (!found || o_valid !== 1'b1) $display("FAIL stalled_valid: setup=%b v=%b want 1/1", found, o_valid);
    else passed++;
    cycle(1'b1, 1'b1, 32'h00000040);
    repeat (8) cycle(1'b0, 1'b0, 32'h0);
  endtask

  // Reset in WAIT, then a stale rvalid during the IDLE cycle.
  task automatic test_reset_in_wait();
    logic found = 1'b0;
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    do_reset();
    for (int t = 0; t < 30 && !found; t++) begin
      if (pend && pdly > 0 && paddr == 32'h4) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0);
    end
    #2 i_rst_n = 1'b0;
    #1;
    total++;
    if (!found || {o_pc, o_instruction, o_pc_plus_4, o_valid, o_imem_req} !== {32'h0, NOP, 32'h4, 1'b0, 1'b0})
      $display("FAIL rst_wait: setup=%b pc=%h ins=%h p4=%h v=%b req=%b want 1 0/00000013/4/0/0",
               found, o_pc, o_instruction, o_pc_plus_4, o_valid, o_imem_req);
    else passed++;
    pend = 1'b0; exp_pc = 32'h0;
    i_stall = 1'b0; i_redirect = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEADBEEF;
    @(negedge i_clk);
    i_imem_rvalid = 1'b0;
    total++;
    if (o_valid !== 1'b0 || o_instruction !== NOP || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0)
      $display("FAIL rst_late_rvalid: v=%b ins=%h req=%b addr=%h want 0/00000013/1/00000000", o_valid, o_instruction, o_imem_req, o_imem_addr);
    else passed++;
    lat_min = 0; lat_max = 0;
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
  endtask

  // Random grant/latency/stall/redirect traffic, including PC wrap.
  task automatic test_random();
    int c0;
    logic [31:0] tgt;
    gnt_pct = 70; lat_min = 0; lat_max = 3;
    do_reset();
    c0 = consumed;
    for (int t = 0; t < 1500; t++) begin
      tgt = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, tgt);
    end
    total++;
    if (consumed - c0 < 100) $display("FAIL random_progress: consumed=%0d want >=100", consumed - c0);
    else passed++;
  endtask

  initial begin
    consumed = 0;
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_rvalid();
    test_redirect_stalled();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
